// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with occupancy flags and error pulses.
// Read port is either registered (FWFT=0) or first-word-fall-through (FWFT=1).
module param_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A read frees a slot in the same edge, so a full FIFO still takes the write.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rstn && wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && !wr_ok;
            underflow <= rd_en && empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [WIDTH-1:0] dout_q;
        logic             rd_valid_q;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                dout_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok;
                if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end
        end

        assign dout     = dout_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
        // Masked while empty so stale storage never leaks after reset.
        assign dout     = empty ? '0 : mem[rd_ptr];
        assign rd_valid = !empty;
    end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: queue model checked every cycle on both read modes.
// Directed sequences add hand-computed literal expectations.
module tb_param_fifo;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [W-1:0]  din;
    logic          rd_en;

    logic [W-1:0]  dout0, dout1;
    logic          vld0, vld1;
    logic          emp0, emp1, ful0, ful1;
    logic          ae0, ae1, af0, af1;
    logic [CW-1:0] cnt0, cnt1;
    logic          ovf0, ovf1, udf0, udf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_TH(6),
                 .AEMPTY_TH(2), .FWFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout0), .rd_valid(vld0),
        .empty(emp0), .full(ful0), .almost_empty(ae0),
        .almost_full(af0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0));

    param_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_TH(6),
                 .AEMPTY_TH(2), .FWFT(1)) dut1 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout1), .rd_valid(vld1),
        .empty(emp1), .full(ful1), .almost_empty(ae1),
        .almost_full(af1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered queue of stored words.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_vld, m_ovf, m_udf;
    bit           chk_on = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            q.delete();
            m_dout = '0;
            m_vld  = 0;
            m_ovf  = 0;
            m_udf  = 0;
            chk_on = 1;
        end else begin
            automatic bit r_ok = rd_en && q.size() > 0;
            automatic bit w_ok = wr_en && (q.size() < D || r_ok);
            m_ovf = wr_en && !w_ok;
            m_udf = rd_en && q.size() == 0;
            m_vld = r_ok;
            if (r_ok) m_dout = q.pop_front();
            if (w_ok) q.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            automatic int n = q.size();
            chk("count0", 32'(cnt0), n);
            chk("count1", 32'(cnt1), n);
            chk("empty0", 32'(emp0), 32'(n == 0));
            chk("empty1", 32'(emp1), 32'(n == 0));
            chk("full0", 32'(ful0), 32'(n == D));
            chk("full1", 32'(ful1), 32'(n == D));
            chk("afull0", 32'(af0), 32'(n >= 6));
            chk("afull1", 32'(af1), 32'(n >= 6));
            chk("aempty0", 32'(ae0), 32'(n <= 2));
            chk("aempty1", 32'(ae1), 32'(n <= 2));
            chk("ovf0", 32'(ovf0), 32'(m_ovf));
            chk("ovf1", 32'(ovf1), 32'(m_ovf));
            chk("udf0", 32'(udf0), 32'(m_udf));
            chk("udf1", 32'(udf1), 32'(m_udf));
            chk("vld0", 32'(vld0), 32'(m_vld));
            chk("dout0", 32'(dout0), 32'(m_dout));
            chk("vld1", 32'(vld1), 32'(n > 0));
            if (n > 0) chk("dout1", 32'(dout1), 32'(q[0]));
        end
    end

    task automatic cycle(input bit w, input logic [W-1:0] d,
                         input bit r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] wq[$];
    logic [W-1:0] rq[$];

    initial begin
        rstn = 0; wr_en = 0; rd_en = 0; din = '0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_empty", 32'(emp0), 1);
        chk("rst_aempty", 32'(ae0), 1);
        chk("rst_full", 32'(ful0), 0);
        chk("rst_afull", 32'(af0), 0);
        chk("rst_dout", 32'(dout0), 0);
        chk("rst_vld", 32'(vld0), 0);
        chk("rst_vld1", 32'(vld1), 0);
        rstn = 1;

        // Fill, then one write too many.
        for (int i = 1; i <= 8; i++) begin
            cycle(1, W'(i), 0);
            chk("fill_afull", 32'(af0), 32'(i >= 6));
        end
        chk("fill_count", 32'(cnt0), 8);
        chk("fill_full", 32'(ful0), 1);
        cycle(1, 16'h0009, 0);
        chk("ovf_pulse", 32'(ovf0), 1);
        chk("ovf_count", 32'(cnt0), 8);
        cycle(0, 0, 0);
        chk("ovf_clear", 32'(ovf0), 0);

        // Drain with registered read, then one read too many.
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 0, 1);
            chk("drain_dout", 32'(dout0), i);
            chk("drain_vld", 32'(vld0), 1);
        end
        cycle(0, 0, 0);
        chk("drain_vld_off", 32'(vld0), 0);
        chk("drain_empty", 32'(emp0), 1);
        cycle(0, 0, 1);
        chk("udf_pulse", 32'(udf0), 1);
        chk("udf_dout", 32'(dout0), 16'h0008);

        // Simultaneous read and write while full.
        for (int i = 1; i <= 8; i++) cycle(1, W'(i), 0);
        cycle(1, 16'h00AA, 1);
        chk("rw_full_count", 32'(cnt0), 8);
        chk("rw_full_ovf", 32'(ovf0), 0);
        chk("rw_full_dout", 32'(dout0), 1);
        for (int i = 2; i <= 8; i++) begin
            cycle(0, 0, 1);
            chk("rw_order", 32'(dout0), i);
        end
        cycle(0, 0, 1);
        chk("rw_last", 32'(dout0), 16'h00AA);

        // Empty with read and write: write only, underflow.
        cycle(1, 16'h0055, 1);
        chk("emp_rw_count", 32'(cnt0), 1);
        chk("emp_rw_udf", 32'(udf0), 1);
        cycle(0, 0, 1);
        chk("emp_rw_dout", 32'(dout0), 16'h0055);

        // Wrap: count held in 3..4, 18 writes total.
        for (int i = 0; i < 3; i++) begin
            wq.push_back(W'(16'h0100 + i));
            cycle(1, W'(16'h0100 + i), 0);
        end
        for (int i = 0; i < 20; i++) begin
            automatic bit w = (i % 4) != 3;
            automatic bit r = (i % 4) != 1;
            automatic logic [W-1:0] d = W'(16'h0200 + i);
            if (w) wq.push_back(d);
            cycle(w, d, r);
            if (r) rq.push_back(dout0);
            chk("wrap_range", 32'(cnt0 >= 3 && cnt0 <= 5), 1);
        end
        while (!emp0 && rq.size() < 40) begin
            cycle(0, 0, 1);
            rq.push_back(dout0);
        end
        chk("wrap_len", rq.size(), 18);
        for (int i = 0; i < 18 && i < rq.size(); i++)
            chk("wrap_data", 32'(rq[i]), 32'(wq[i]));

        // FWFT: word falls through one cycle after the write.
        cycle(1, 16'h1234, 0);
        chk("fwft_dout", 32'(dout1), 16'h1234);
        chk("fwft_vld", 32'(vld1), 1);
        cycle(0, 0, 1);
        chk("fwft_empty", 32'(emp1), 1);
        chk("fwft_vld_off", 32'(vld1), 0);

        // Reset mid-traffic, requests ignored during reset.
        for (int i = 1; i <= 5; i++) cycle(1, W'(16'h0300 + i), 0);
        chk("pre_rst_count", 32'(cnt0), 5);
        rstn = 0;
        cycle(1, 16'h0EEE, 1);
        rstn = 1;
        chk("mid_rst_count", 32'(cnt0), 0);
        chk("mid_rst_empty", 32'(emp0), 1);
        chk("mid_rst_vld1", 32'(vld1), 0);
        cycle(1, 16'h00BB, 0);
        chk("post_rst_fwft", 32'(dout1), 16'h00BB);
        cycle(0, 0, 1);
        chk("post_rst_dout", 32'(dout0), 16'h00BB);
        cycle(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 The block SHALL provide parameter DEPTH, default 16, number of storage entries (power of two, >=2).
REQ-003 The block SHALL provide parameter AFULL_TH, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 The block SHALL provide parameter AEMPTY_TH, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 The block SHALL provide parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 The block SHALL provide port rstn, input, 1, reset: synchronous, active-low.
REQ-008 The block SHALL provide port wr_en, input, 1, write request.
REQ-009 The block SHALL provide port din, input, WIDTH, write data.
REQ-010 The block SHALL provide port rd_en, input, 1, read request.
REQ-011 The block SHALL provide port dout, output, WIDTH, read data.
REQ-012 The block SHALL provide port rd_valid, output, 1, dout carries a newly popped word (FWFT=0) or the head word (FWFT=1).
REQ-013 The block SHALL provide ports empty, full, almost_empty and almost_full, each output, 1, status flags.
REQ-014 The block SHALL provide port count, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-015 The block SHALL provide ports overflow and underflow, each output, 1, single-cycle error pulses.

Function
REQ-016 Write accept (wr_ok): wr_en && (!full || rd_ok); the word is stored at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-017 Read accept (rd_ok): rd_en && !empty; rd_ptr advances modulo DEPTH.
REQ-018 count SHALL change as follows: +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
REQ-019 Flags SHALL be combinational from registered count: empty = (count==0); full = (count==DEPTH); almost_full = (count>=AFULL_TH); almost_empty = (count<=AEMPTY_TH).
REQ-020 FWFT=0: on rd_ok, dout SHALL load mem[rd_ptr] at the same edge and rd_valid SHALL be 1 for exactly the following cycle (latency 1).
REQ-021 FWFT=0: without rd_ok, dout SHALL hold its last value and rd_valid SHALL be 0.
REQ-022 FWFT=1: dout SHALL equal mem[rd_ptr] combinationally and rd_valid = !empty; rd_en acts as a pop acknowledge.
REQ-023 FWFT=1: a word written into an empty FIFO SHALL appear on dout, with rd_valid=1, in the cycle after the write edge.
REQ-024 When full, wr_en && rd_en SHALL accept both operations; count stays DEPTH and FIFO order is preserved.
REQ-025 When empty, wr_en && rd_en SHALL accept the write only, reject the read and pulse underflow; count becomes 1.
REQ-026 overflow SHALL be 1 for the cycle after wr_en && !wr_ok, and 0 otherwise; the rejected data SHALL be dropped and no state SHALL change.
REQ-027 underflow SHALL be 1 for the cycle after rd_en && empty, and 0 otherwise; pointers and dout SHALL be unchanged.
REQ-028 Pointer wrap SHALL be seamless: entry DEPTH-1 is followed by entry 0, with no lost or duplicated word.
REQ-029 Data order SHALL be strict FIFO under any interleaving of wr_en and rd_en.

Reset
REQ-030 While rstn=0 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, dout=0, rd_valid=0, overflow=0, underflow=0.
REQ-031 The resulting flags SHALL be empty=1, almost_empty=1, full=0, almost_full=0.
REQ-032 Storage contents are not reset; after reset they SHALL never be observable on dout with rd_valid=1.
REQ-033 Reset asserted mid-traffic SHALL discard all stored words and pending requests in that cycle; wr_en and rd_en SHALL be ignored while rstn=0.

Verification
(WIDTH=16, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2 unless noted)
REQ-034 Fill: write 0x0001..0x0008 -> count=8, full=1, and almost_full=1 from count 6; a 9th write -> overflow pulse, count stays 8.
REQ-035 Drain, FWFT=0: 8 reads -> dout 0x0001..0x0008, each with a 1-cycle rd_valid; then empty=1; an extra read -> underflow pulse, dout stays 0x0008.
REQ-036 Full plus simultaneous rd/wr of 0x00AA -> count stays 8, no overflow; the next 8 reads -> 0x0002..0x0008, then 0x00AA.
REQ-037 Wrap: 20 interleaved write/read cycles at count 3..5 -> pointers wrap at least twice, and the read stream equals the write stream exactly.
REQ-038 FWFT=1: write 0x1234 into empty -> next cycle dout=0x1234 and rd_valid=1; rd_en -> following cycle empty=1 and rd_valid=0.
REQ-039 Reset mid-operation: at count=5, pulse rstn=0 for 1 cycle -> count=0 and empty=1; then write 0x00BB and read -> dout=0x00BB.
